// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl
// Main-memory model for the L1 miss path. It services one request at a time:
// either a line fill (read) or a line write-back. A line is BEATS beats of
// DATA_W bits, and one beat moves per cycle. A fixed LATENCY models the access
// time. The read latency comes before the data phase; the write latency comes
// after it.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        synchronous active-high reset (the backing store keeps its contents)
//   req_valid  request present; accepted when req_valid && MM_ready
//   req_write  1 = write-back, 0 = line fill; sampled at accept
//   req_addr   byte address of the line; offset bits and bits above the line index are ignored
//   MM_ready   high only while idle
//   wr_data    write-back beat
//   wr_valid   wr_data valid
//   wr_ready   a beat is taken on wr_valid && wr_ready
//   rd_data    fill beat, driven straight from the RAM output register
//   rd_valid   rd_data valid; there is no backpressure
//   rd_last    marks beat BEATS-1
//   done       one-cycle pulse when a transaction completes
//
// BEATS must be a power of 2 and at least 2. LATENCY must be at least 1.
module main_memory_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BEATS     = 8,
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              MM_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              done
);

  localparam int OFF_W  = $clog2(BEATS * DATA_W / 8);
  localparam int LINE_W = $clog2(MEM_LINES);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LAT_W  = $clog2(LATENCY) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, WR_BEATS, WR_WAIT, RD_WAIT, RD_BEATS, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                mem_we;
  logic                mem_re;
  logic [BEAT_W-1:0]   rd_beat;

  // Backing store. It is word-addressed by {line, beat}.
  logic [DATA_W-1:0]   mem [MEM_LINES*BEATS];

  // Only the line-index bits of the address are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:OFF_W+LINE_W], req_addr[OFF_W-1:0]};

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    beat_cnt_d = beat_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    MM_ready   = 1'b0;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    done       = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    rd_beat    = '0;

    unique case (state_q)
      IDLE: begin
        MM_ready = 1'b1;
        if (req_valid) begin
          line_d     = req_addr[OFF_W+LINE_W-1:OFF_W];
          beat_cnt_d = '0;
          lat_cnt_d  = '0;
          state_d    = req_write ? WR_BEATS : RD_WAIT;
        end
      end
      WR_BEATS: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = WR_WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      WR_WAIT: begin
        if (lat_cnt_q == LAST_LAT) begin
          lat_cnt_d = '0;
          state_d   = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      RD_WAIT: begin
        // The RAM read is registered, so beat 0 is fetched during the last
        // wait cycle. That way it is on rd_data in the first RD_BEATS cycle.
        if (lat_cnt_q == LAST_LAT) begin
          lat_cnt_d = '0;
          mem_re    = 1'b1;
          rd_beat   = '0;
          state_d   = RD_BEATS;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      RD_BEATS: begin
        rd_valid = 1'b1;
        if (beat_cnt_q == LAST_BEAT) begin
          rd_last    = 1'b1;
          beat_cnt_d = '0;
          state_d    = DONE;
        end else begin
          // Fetch ahead: the beat shown this cycle was read one cycle earlier.
          mem_re     = 1'b1;
          rd_beat    = beat_cnt_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      beat_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      beat_cnt_q <= beat_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  // Store write port. Reset blocks a write in the same cycle but never clears the store.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[{line_q, beat_cnt_q}] <= wr_data;
    end
  end

  // Registered read port. This register is also the rd_data output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (mem_re) begin
      rd_data_q <= mem[{line_q, rd_beat}];
    end
  end

  assign rd_data = rd_data_q;

endmodule
